// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: assembles a 32-bit little-endian instruction from
// four byte reads of a synchronous memory, with a one-entry last-fetch buffer.
module inst_fetch_resp #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              ce,
  input  logic              flush,
  output logic              busy,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_rd,
  input  logic [7:0]        mem_din
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R0   = 3'd1,
    R1   = 3'd2,
    R2   = 3'd3,
    R3   = 3'd4,
    W    = 3'd5
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  base_q;
  logic [23:0]        asm_q;
  logic [29:0]        pc_hi_q;
  logic [31:0]        last_pc_q;
  logic               last_ok_q;
  logic [31:0]        inst_q;
  logic               valid_q;
  logic               mis_q;
  logic [1:0]         off_s;
  logic               rd_s;

  // Memory address offset and read strobe decoded from the current read state.
  always_comb begin
    off_s = 2'd0;
    rd_s  = 1'b0;
    case (state_q)
      R0:      begin off_s = 2'd0; rd_s = 1'b1; end
      R1:      begin off_s = 2'd1; rd_s = 1'b1; end
      R2:      begin off_s = 2'd2; rd_s = 1'b1; end
      R3:      begin off_s = 2'd3; rd_s = 1'b1; end
      default: begin off_s = 2'd0; rd_s = 1'b0; end
    endcase
  end

  assign mem_a      = base_q + ADDR_W'(off_s);
  assign mem_rd     = rd_s;
  assign busy       = (state_q != IDLE);
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign misalign   = mis_q;

  // Fetch FSM; byte k-1 arrives on mem_din while in state R(k) and is taken on the leaving edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      asm_q     <= 24'h0;
      pc_hi_q   <= 30'h0;
      last_pc_q <= 32'h0;
      last_ok_q <= 1'b0;
      inst_q    <= 32'h0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      if (flush) begin
        state_q   <= IDLE;
        last_ok_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ce) begin
              if (pc[1:0] != 2'b00) begin
                mis_q <= 1'b1;
              end else if (last_ok_q && (pc == last_pc_q)) begin
                valid_q <= 1'b1;
              end else begin
                base_q  <= pc[ADDR_W-1:0];
                pc_hi_q <= pc[31:2];
                state_q <= R0;
              end
            end
          end
          R0: state_q <= R1;
          R1: begin
            asm_q[7:0] <= mem_din;
            state_q    <= R2;
          end
          R2: begin
            asm_q[15:8] <= mem_din;
            state_q     <= R3;
          end
          R3: begin
            asm_q[23:16] <= mem_din;
            state_q      <= W;
          end
          W: begin
            inst_q    <= {mem_din, asm_q};
            valid_q   <= 1'b1;
            last_pc_q <= {pc_hi_q, 2'b00};
            last_ok_q <= 1'b1;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp: byte memory model, scoreboard of expected pulses,
// address-trace and latency checks around misses, hits, misalignment, flush and reset.
module tb_inst_fetch_resp;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       pc = 32'h0;
  logic              ce = 1'b0;
  logic              flush = 1'b0;
  logic              busy;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              misalign;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_rd;
  logic [7:0]        mem_din = 8'h0;

  typedef struct {
    logic        mis;
    logic [31:0] inst;
  } exp_t;

  exp_t              sb[$];
  logic [ADDR_W-1:0] rd_trace[$];
  logic [7:0]        mem[0:(1<<ADDR_W)-1];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                pulse_cyc = 0;
  logic [31:0]       exp14;
  logic [31:0]       exp1fffc;

  inst_fetch_resp #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .flush(flush), .busy(busy),
    .inst(inst), .inst_valid(inst_valid), .misalign(misalign),
    .mem_a(mem_a), .mem_rd(mem_rd), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte memory: data appears one cycle after the address.
  always @(posedge clk) mem_din <= mem[mem_a];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] a1, a2, a3;
    a1 = a + 17'd1;
    a2 = a + 17'd2;
    a3 = a + 17'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  // Output monitor: records read addresses and retires scoreboard entries on each pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mem_rd) rd_trace.push_back(mem_a);
    if (inst_valid || misalign) begin
      pulse_cyc = cyc;
      check("pulse_exclusive", {31'd0, inst_valid & misalign}, 32'd0);
      check("pulse_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pulse_kind", {31'd0, misalign}, {31'd0, e.mis});
        if (!e.mis) check("pulse_inst", inst, e.inst);
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic mis, input logic [31:0] ei,
                       input int nrd, input logic [ADDR_W-1:0] a0);
    int nb;
    int acc;
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    rd_trace.delete();
    pc = a;
    ce = 1'b1;
    sb.push_back('{mis, ei});
    acc = cyc + 1;
    @(negedge clk);
    ce = 1'b0;
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    #1;
    check("busy_cycles", nb, (nrd == 4) ? 32'd5 : 32'd0);
    check("pulse_seen", sb.size(), 32'd0);
    check("latency", pulse_cyc - acc, (nrd == 4) ? 32'd5 : 32'd0);
    check("rd_count", rd_trace.size(), nrd);
    for (int k = 0; k < nrd && k < rd_trace.size(); k++) begin
      ea = a0 + 17'(k);
      check("rd_addr", {15'd0, rd_trace[k]}, {15'd0, ea});
    end
    check("inst_value", inst, ei);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i * 7) ^ 8'hA5;
    mem[17'h10] = 8'h13;
    mem[17'h11] = 8'h05;
    mem[17'h12] = 8'h50;
    mem[17'h13] = 8'h00;
    exp14    = word_at(17'h14);
    exp1fffc = word_at(17'h1FFFC);

    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_a", {15'd0, mem_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Miss, hit, second miss, misaligned.
    fetch(32'h10, 1'b0, 32'h00500513, 4, 17'h10);
    fetch(32'h10, 1'b0, 32'h00500513, 0, 17'h0);
    fetch(32'h14, 1'b0, exp14, 4, 17'h14);
    fetch(32'h22, 1'b1, exp14, 0, 17'h0);
    check("misalign_busy", {31'd0, busy}, 32'd0);

    // Top of the address space and a truncated alias of it.
    fetch(32'h1FFFC, 1'b0, exp1fffc, 4, 17'h1FFFC);
    fetch(32'h3FFFC, 1'b0, exp1fffc, 4, 17'h1FFFC);

    // Back-to-back hits accept on every edge.
    @(negedge clk);
    pc = 32'h3FFFC;
    ce = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back('{1'b0, exp1fffc});
    repeat (3) @(negedge clk);
    ce = 1'b0;
    #1;
    check("b2b_hits", sb.size(), 32'd0);

    // Flush in R2 abandons the fetch and invalidates the buffer.
    @(negedge clk);
    pc = 32'h40;
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("flush_no_pulse", sb.size(), 32'd0);
    fetch(32'h3FFFC, 1'b0, exp1fffc, 4, 17'h1FFFC);

    // Flush together with ce in IDLE drops the request (it would otherwise hit).
    @(negedge clk);
    pc = 32'h3FFFC;
    ce = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_ce_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    fetch(32'h3FFFC, 1'b0, exp1fffc, 4, 17'h1FFFC);

    // Asynchronous reset while in R1.
    @(negedge clk);
    pc = 32'h14;
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_inst", inst, 32'h0);
    check("arst_no_pulse", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
